irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller for the 8-bit soft processor; arbitrates up to NUM_SRC peripheral interrupt lines into one interrupt request.
- Supplies the 12-bit jump vector for the program counter and sequences one interrupt at a time: request, acknowledge, service, return.
- Software configures it through the processor I/O port bus: port_id, write_strobe, out_data, and the in_data return path.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..8); priority is fixed, index 0 highest.
- BASE_PORT, 8'hF0, I/O port of register 0; the block decodes BASE_PORT..BASE_PORT+3.
- VECTOR_BASE, 12'h3F0, instruction address of source 0's vector.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq_src  input  NUM_SRC  raw peripheral interrupt lines, asynchronous to clk; rising-edge sensitive.
- port_id  input  8  processor I/O port address.
- write_strobe  input  1  processor OUTPUT strobe, one cycle.
- out_data  input  8  processor OUTPUT data.
- rd_data  output  8  register read data to processor in_data mux; combinational on port_id.
- irq_req  output  1  interrupt request to control unit.
- irq_ack  input  1  control unit accepted interrupt, one cycle.
- irq_done  input  1  control unit executed return-from-interrupt, one cycle.
- irq_vector  output  12  jump address, valid while irq_req=1.
- irq_active  output  1  an interrupt is being serviced.

Behaviour:
- Reset (reset=0, async): all outputs, sync flops, PEND, MASK and CTRL become 0; FSM goes to IDLE.
- Input sync: irq_src passes through 2 flops, then an edge-detect flop. rise = sync2 & ~sync3.
- Latency: a src rise before edge k sets PEND at edge k+2.
- PEND bit set on rise. A bit already set stays set; edges are not counted.
- Registers (offset from BASE_PORT):
  - +0 MASK: R/W, 1 = enabled.
  - +1 PEND: R; writing 1 to a bit clears it.
  - +2 STATUS: R only; bit7 = irq_active, bit6 = irq_req, bits2:0 = current id, other bits 0.
  - +3 CTRL: R/W; bit0 = global enable, other bits read 0.
- Writes take effect at the edge where write_strobe=1 and port_id matches.
- rd_data = 0 for unmapped ports. Reads have no side effects.
- Bits at or above NUM_SRC read 0 and ignore writes.
- Set/clear priority: a rise always beats a same-cycle W1C clear or ack clear of the same bit.
- FSM states: IDLE, REQ, ACTIVE.
  - IDLE: if CTRL[0] and |(PEND & MASK), latch id = lowest set index of PEND & MASK, go to REQ. irq_req rises the cycle after the qualifying PEND bit is visible.
  - REQ: irq_req=1 and irq_vector = VECTOR_BASE + id, both held stable. Request is committed: mask or enable changes do not withdraw it. On irq_ack, clear PEND[id] and go to ACTIVE; irq_req=0 next cycle.
  - ACTIVE: irq_active=1, irq_vector holds. No new request (no nesting). On irq_done, go to IDLE.
- Back-to-back: if other enabled bits are pending, the next irq_req asserts 1 cycle after IDLE is re-entered.
- Ignored strobes: irq_ack outside REQ; irq_done outside ACTIVE.
- Simultaneous ack and done are impossible by FSM state; no special case.
- irq_vector = 0 in IDLE.
- Vector arithmetic is 12-bit and wraps modulo 4096.

Test Plan:
- Reset values: hold reset=0 with irq_src toggling, then release. MASK, PEND, CTRL, STATUS read 8'h00; irq_req=0, irq_vector=0.
- Single interrupt: write MASK=8'h04, CTRL=8'h01, pulse irq_src[2]. PEND reads 8'h04 two edges after the rise; irq_req=1 with irq_vector=12'h3F2. Pulse irq_ack: PEND=0, irq_active=1, STATUS=8'h82. Pulse irq_done: back to IDLE.
- Priority: MASK=8'hFF, CTRL=1, raise src[5] and src[1] together. First vector 12'h3F1; after ack+done, next vector 12'h3F5 one cycle after IDLE.
- Masking and commitment:
  - src[3] with MASK=0: PEND=8'h08, no irq_req.
  - Set MASK bit 3: irq_req asserts.
  - Clear MASK while in REQ: irq_req stays 1 until ack.
- Races:
  - W1C of PEND bit 0 in the same cycle as a new src[0] rise: bit stays 1.
  - irq_ack in IDLE and irq_done in REQ: no state change.
- Async reset mid-service: assert reset in ACTIVE. irq_active drops immediately, without waiting for clk; all registers read 0 after release.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller for the 8-bit soft processor.
// It synchronises the peripheral lines and latches rising edges into PEND.
// It arbitrates PEND & MASK by fixed priority (index 0 wins) and runs one
// interrupt at a time through request, acknowledge, service and return.
module irq_ctrl #(
  parameter int          NUM_SRC     = 8,
  parameter logic [7:0]  BASE_PORT   = 8'hF0,
  parameter logic [11:0] VECTOR_BASE = 12'h3F0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic [7:0]         out_data,
  output logic [7:0]         rd_data,
  output logic               irq_req,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic [11:0]        irq_vector,
  output logic               irq_active
);

  // Register bits that correspond to real sources. Higher bits read 0 and
  // ignore writes.
  localparam logic [7:0] SRC_MASK = 8'((16'd1 << NUM_SRC) - 16'd1);

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

  state_t             state;
  logic [2:0]         id;
  logic [NUM_SRC-1:0] sync1, sync2, sync3;
  logic [7:0]         rise;
  logic [7:0]         mask, pend;
  logic               ctrl_en;

  logic [7:0]         offset;
  logic               hit, wr_mask, wr_pend, wr_ctrl;
  logic [7:0]         w1c, ack_clr, cand;
  logic [2:0]         pick;

  // Two-flop synchroniser followed by an edge-detect flop.
  // NOTE: sequential state always uses non-blocking (<=) assignments so every
  // flop samples pre-edge values and the chain shifts by one stage per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Zero-extend the per-source rise pulses to register width.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    rise                = '0;
    rise[NUM_SRC-1:0]   = sync2 & ~sync3;
  end

  // Port decode. The subtraction wraps, so the four-port window follows
  // BASE_PORT.
  assign offset  = port_id - BASE_PORT;
  assign hit     = (offset[7:2] == 6'd0);
  assign wr_mask = write_strobe && hit && (offset[1:0] == 2'd0);
  assign wr_pend = write_strobe && hit && (offset[1:0] == 2'd1);
  assign wr_ctrl = write_strobe && hit && (offset[1:0] == 2'd3);

  assign w1c     = wr_pend ? (out_data & SRC_MASK) : 8'd0;
  assign ack_clr = (state == REQ && irq_ack) ? (8'd1 << id) : 8'd0;
  assign cand    = pend & mask;

  // Lowest set index of the enabled pending bits. The loop runs downward so
  // that the last match, which is the lowest index, wins.
  always_comb begin
    pick = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) pick = 3'(i);
    end
  end

  // Software-visible registers. Clears are applied first and the rise is
  // ORed in last, so a new edge always beats a same-cycle clear of that bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask    <= '0;
      pend    <= '0;
      ctrl_en <= 1'b0;
    end else begin
      if (wr_mask) mask <= out_data & SRC_MASK;
      if (wr_ctrl) ctrl_en <= out_data[0];
      pend <= ((pend & ~w1c & ~ack_clr) | rise) & SRC_MASK;
    end
  end

  // Sequencer: IDLE -> REQ (committed) -> ACTIVE -> IDLE. Outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      id         <= 3'd0;
      irq_req    <= 1'b0;
      irq_active <= 1'b0;
      irq_vector <= 12'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl_en && (cand != 8'd0)) begin
            state      <= REQ;
            id         <= pick;
            irq_req    <= 1'b1;
            irq_vector <= VECTOR_BASE + {9'd0, pick};
          end
        end
        REQ: begin
          if (irq_ack) begin
            state      <= ACTIVE;
            irq_req    <= 1'b0;
            irq_active <= 1'b1;
          end
        end
        ACTIVE: begin
          if (irq_done) begin
            state      <= IDLE;
            id         <= 3'd0;
            irq_active <= 1'b0;
            irq_vector <= 12'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read mux. It decodes port_id combinationally and has no side effects.
  always_comb begin
    rd_data = 8'd0;
    if (hit) begin
      unique case (offset[1:0])
        2'd0: rd_data = mask;
        2'd1: rd_data = pend;
        2'd2: rd_data = {irq_active, irq_req, 3'b000, id};
        2'd3: rd_data = {7'd0, ctrl_en};
        default: rd_data = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Inputs change and outputs are sampled on the
// falling edge.
module tb_irq_ctrl;

  localparam logic [7:0] BASE = 8'hF0;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic [7:0]  out_data;
  logic [7:0]  rd_data;
  logic        irq_req;
  logic        irq_ack;
  logic        irq_done;
  logic [11:0] irq_vector;
  logic        irq_active;

  int checks = 0;
  int errors = 0;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .port_id(port_id),
    .write_strobe(write_strobe), .out_data(out_data), .rd_data(rd_data),
    .irq_req(irq_req), .irq_ack(irq_ack), .irq_done(irq_done),
    .irq_vector(irq_vector), .irq_active(irq_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Combinational read. It is called at a falling edge and consumes no clock.
  task automatic rd(input logic [1:0] off, input logic [7:0] exp, input string tag);
    port_id = BASE + {6'd0, off};
    #1;
    check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] data);
    port_id      = BASE + {6'd0, off};
    out_data     = data;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    @(negedge clk);
    irq_done = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_src = 8'h00; port_id = 8'h00; write_strobe = 1'b0;
    out_data = 8'h00; irq_ack = 1'b0; irq_done = 1'b0;

    // Reset with the source lines toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      irq_src = ~irq_src;
    end
    irq_src = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    rd(2'd0, 8'h00, "rst_mask");
    rd(2'd1, 8'h00, "rst_pend");
    rd(2'd2, 8'h00, "rst_status");
    rd(2'd3, 8'h00, "rst_ctrl");
    check("rst_req", {31'd0, irq_req}, 32'd0);
    check("rst_vec", {20'd0, irq_vector}, 32'd0);

    // Single interrupt on source 2, including the edge latency.
    wr(2'd0, 8'h04);
    wr(2'd3, 8'hFF);
    rd(2'd0, 8'h04, "mask_rb");
    rd(2'd3, 8'h01, "ctrl_rb");
    port_id = 8'h34;
    #1;
    check("unmapped", {24'd0, rd_data}, 32'd0);
    port_id = BASE + 8'd4;
    #1;
    check("unmapped_hi", {24'd0, rd_data}, 32'd0);
    irq_src[2] = 1'b1;
    tick(2);
    rd(2'd1, 8'h00, "pend_early");
    tick(1);
    rd(2'd1, 8'h04, "pend_set");
    check("req_not_yet", {31'd0, irq_req}, 32'd0);
    tick(1);
    irq_src[2] = 1'b0;
    check("single_req", {31'd0, irq_req}, 32'd1);
    check("single_vec", {20'd0, irq_vector}, 32'h3F2);
    pulse_ack();
    rd(2'd1, 8'h00, "single_pend_clr");
    rd(2'd2, 8'h82, "single_status");
    check("single_req_drop", {31'd0, irq_req}, 32'd0);
    check("single_active", {31'd0, irq_active}, 32'd1);
    check("single_vec_hold", {20'd0, irq_vector}, 32'h3F2);
    pulse_done();
    check("single_idle", {31'd0, irq_active}, 32'd0);
    check("single_vec0", {20'd0, irq_vector}, 32'd0);

    // Priority between sources 5 and 1, then back-to-back service.
    wr(2'd0, 8'hFF);
    irq_src = 8'h22;
    tick(4);
    irq_src = 8'h00;
    rd(2'd1, 8'h22, "prio_pend");
    check("prio_vec1", {20'd0, irq_vector}, 32'h3F1);
    rd(2'd2, 8'h41, "prio_status");
    pulse_ack();
    rd(2'd1, 8'h20, "prio_pend_after_ack");
    pulse_done();
    check("b2b_idle_gap", {31'd0, irq_req}, 32'd0);
    tick(1);
    check("b2b_req", {31'd0, irq_req}, 32'd1);
    check("b2b_vec", {20'd0, irq_vector}, 32'h3F5);
    pulse_ack();
    pulse_done();
    rd(2'd1, 8'h00, "prio_pend_empty");

    // Masking and commitment of a request.
    wr(2'd0, 8'h00);
    irq_src[3] = 1'b1;
    tick(4);
    irq_src[3] = 1'b0;
    rd(2'd1, 8'h08, "masked_pend");
    tick(2);
    check("masked_no_req", {31'd0, irq_req}, 32'd0);
    wr(2'd0, 8'h08);
    tick(1);
    check("unmask_req", {31'd0, irq_req}, 32'd1);
    check("unmask_vec", {20'd0, irq_vector}, 32'h3F3);
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h00);
    tick(2);
    check("commit_req", {31'd0, irq_req}, 32'd1);
    check("commit_vec", {20'd0, irq_vector}, 32'h3F3);
    pulse_ack();
    rd(2'd2, 8'h83, "commit_status");
    pulse_done();
    wr(2'd3, 8'h01);

    // A rise beats a same-cycle W1C of the same bit.
    irq_src[0] = 1'b1;
    tick(4);
    irq_src[0] = 1'b0;
    rd(2'd1, 8'h01, "race_pre");
    tick(1);
    irq_src[0] = 1'b1;
    tick(2);
    wr(2'd1, 8'h01);
    rd(2'd1, 8'h01, "race_rise_wins");
    irq_src[0] = 1'b0;
    wr(2'd1, 8'h01);
    rd(2'd1, 8'h00, "w1c_plain");

    // Strobes outside their states are ignored.
    pulse_ack();
    check("ack_idle_active", {31'd0, irq_active}, 32'd0);
    rd(2'd2, 8'h00, "ack_idle_status");
    wr(2'd0, 8'h01);
    irq_src[0] = 1'b1;
    tick(4);
    irq_src[0] = 1'b0;
    check("req_src0", {31'd0, irq_req}, 32'd1);
    pulse_done();
    check("done_req_hold", {31'd0, irq_req}, 32'd1);
    rd(2'd2, 8'h40, "done_req_status");
    pulse_ack();
    rd(2'd2, 8'h80, "active_src0");

    // Asynchronous reset during service.
    #2;
    reset = 1'b0;
    #1;
    check("async_active", {31'd0, irq_active}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    rd(2'd0, 8'h00, "post_mask");
    rd(2'd1, 8'h00, "post_pend");
    rd(2'd2, 8'h00, "post_status");
    rd(2'd3, 8'h00, "post_ctrl");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog that guarantees the run ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
